collenda_mem_copy_master: RTL and testbench

- Avalon-MM master (initiator) that copies a block of 32-bit words inside an on-chip memory slave.
- A command port supplies source word address, destination word address and length; the block issues one read, then one write per word.
- Sits between the control logic and the onchip memory s1/s2 slave ports. It is the initiator end of the same memory-mapped interface.
- One transaction outstanding at a time; handles waitrequest and readdatavalid, so it works with fixed- or variable-latency slaves.

---
 rtl/collenda_mem_copy_master_if.sv | 25 ++
 rtl/collenda_mem_copy_master.sv | 134 +++++++++++++
 tb/tb_collenda_mem_copy_master.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/collenda_mem_copy_master_if.sv
// Avalon-MM bus between the copy master and an on-chip memory slave port.
// The master modport is the initiator side and the slave modport is the memory side.
interface collenda_mem_copy_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;
  logic                avm_waitrequest;

  modport master (
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/collenda_mem_copy_master.sv
// Avalon-MM copy master: reads one word and writes it back, repeated for each word of a block.
// Optional running checksum of the copied words is enabled with COPY_MASTER_CHECKSUM_EN.
module collenda_mem_copy_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_left,
`ifdef COPY_MASTER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [2:0]        dbg_state,
  collenda_mem_copy_master_if.master avm
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  left_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept, capture, wr_acc;

  // Handshake: a request (avm_read or avm_write) is accepted in a cycle where it is
  // high and avm_waitrequest is low; until then request, address and writedata are held.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    wr_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (length == '0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ: begin
        if (!avm.avm_waitrequest) begin
          // Zero-latency slaves may return data in the acceptance cycle itself.
          if (avm.avm_readdatavalid) begin
            capture = 1'b1;
            state_d = WR_REQ;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (avm.avm_readdatavalid) begin
          capture = 1'b1;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (!avm.avm_waitrequest) begin
          wr_acc  = 1'b1;
          state_d = (left_q == LEN_W'(1)) ? FINISH : RD_REQ;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      left_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q  <= src_addr;
        dst_q  <= dst_addr;
        left_q <= length;
      end
      if (capture) wdata_q <= avm.avm_readdata;
      if (wr_acc) begin
        src_q  <= src_q + ADDR_W'(1);
        dst_q  <= dst_q + ADDR_W'(1);
        left_q <= left_q - LEN_W'(1);
      end
    end
  end

`ifdef COPY_MASTER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (capture) begin
      csum_q <= csum_q + avm.avm_readdata;
    end
  end

  assign checksum = csum_q;
`endif

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign words_left = left_q;
  assign dbg_state  = state_q;

  assign avm.avm_read       = (state_q == RD_REQ);
  assign avm.avm_write      = (state_q == WR_REQ);
  assign avm.avm_byteenable = '1;
  assign avm.avm_writedata  = wdata_q;
  always_comb begin
    avm.avm_address = '0;
    if (state_q == RD_REQ) avm.avm_address = src_q;
    if (state_q == WR_REQ) avm.avm_address = dst_q;
  end

endmodule

// File: tb/tb_collenda_mem_copy_master.sv
// Self-checking bench for collenda_mem_copy_master: memory slave model with random stalls and
// read latency, plus a block-copy reference model producing the expected bus traffic and image.
module tb_collenda_mem_copy_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [9:0]  src_addr, dst_addr;
  logic [10:0] length;
  logic        busy, done;
  logic [10:0] words_left;
  logic [2:0]  dbg_state;
`ifdef COPY_MASTER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  collenda_mem_copy_master_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  collenda_mem_copy_master #(.ADDR_W(10), .DATA_W(32), .LEN_W(11)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .words_left (words_left),
`ifdef COPY_MASTER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .dbg_state  (dbg_state),
    .avm        (bus.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory + reference model ----------------
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic [41:0] exp_q[$];     // expected writes {addr, data}
  logic [9:0]  exp_rd_q[$];  // expected read addresses
  logic [31:0] exp_sum;

  // A copy is a strictly ascending word-by-word move with 10-bit address wrap.
  task automatic model_prepare(input logic [9:0] s, input logic [9:0] d, input logic [10:0] len);
    logic [9:0]  sp, dp;
    logic [31:0] w;
    sp = s;
    dp = d;
    exp_sum = 32'h0;
    for (int i = 0; i < int'(len); i++) begin
      w = ref_mem[sp];
      exp_sum = exp_sum + w;
      ref_mem[dp] = w;
      exp_rd_q.push_back(sp);
      exp_q.push_back({dp, w});
      sp = sp + 10'd1;
      dp = dp + 10'd1;
    end
  endtask

  // ---------------- slave model ----------------
  int          wait_pct = 0;
  int          lat_lo = 1, lat_hi = 1;
  bit          spur_en = 0;
  int          done_cnt = 0, act_cnt = 0, wr_cnt = 0;
  int          cnt = 0;
  logic [31:0] pend;
  logic        rd_acc, wr_acc, prev_rd, prev_wr;
  logic [9:0]  s_addr, prev_addr;
  logic [31:0] s_data, prev_data;
  logic [41:0] e_wr;
  logic [9:0]  e_rd;

  initial begin
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = 32'h0;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      rd_acc = bus.avm_read  && !bus.avm_waitrequest;
      wr_acc = bus.avm_write && !bus.avm_waitrequest;
      s_addr = bus.avm_address;
      s_data = bus.avm_writedata;
      if (reset_n) begin
        if (bus.avm_read || bus.avm_write) begin
          act_cnt++;
          check("rw_exclusive", {63'd0, bus.avm_read & bus.avm_write}, 64'd0);
          check("byteenable", {60'd0, bus.avm_byteenable}, 64'hF);
        end
        if (done) done_cnt++;
        if (prev_rd) check("rd_hold", {bus.avm_read, bus.avm_address}, {1'b1, prev_addr});
        if (prev_wr) check("wr_hold", {bus.avm_write, bus.avm_address, bus.avm_writedata},
                           {1'b1, prev_addr, prev_data});
        prev_rd   = bus.avm_read  && bus.avm_waitrequest;
        prev_wr   = bus.avm_write && bus.avm_waitrequest;
        prev_addr = bus.avm_address;
        prev_data = bus.avm_writedata;
      end else begin
        rd_acc  = 1'b0;
        wr_acc  = 1'b0;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.avm_readdatavalid = 1'b0;
      if (!reset_n) begin
        cnt = 0;
        bus.avm_waitrequest = 1'b0;
      end else begin
        if (wr_acc) begin
          wr_cnt++;
          if (exp_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
          else begin
            e_wr = exp_q.pop_front();
            check("wr_txn", {22'd0, s_addr, s_data}, {22'd0, e_wr});
          end
          mem[s_addr] = s_data;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = pend;
          end
        end
        if (rd_acc) begin
          if (exp_rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
          else begin
            e_rd = exp_rd_q.pop_front();
            check("rd_addr", {54'd0, s_addr}, {54'd0, e_rd});
          end
          pend = mem[s_addr];
          cnt  = $urandom_range(lat_hi, lat_lo);
        end
        // Junk valid pulses while the master is writing must be ignored.
        if (spur_en && !bus.avm_readdatavalid && bus.avm_write && ($urandom_range(0, 1) == 1)) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata      = $urandom;
        end
        bus.avm_waitrequest = ($urandom_range(0, 99) < wait_pct);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] len,
                          input int exp_cyc);
    int got;
    int bad;
    ref_mem = mem;
    model_prepare(s, d, len);
    done_cnt = 0;
    act_cnt  = 0;
    @(posedge clk);
    #1;
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    length   = len;
    @(posedge clk);
    #1;
    start    = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    length   = $urandom;
    got = -1;
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("words_left_init", {53'd0, words_left}, {53'd0, len});
`ifdef COPY_MASTER_CHECKSUM_EN
        check("csum_cleared", {32'd0, checksum}, 64'd0);
`endif
      end
      if (done) begin
        got = n;
        break;
      end
    end
    if (exp_cyc > 0) check("done_latency", 64'(got), 64'(exp_cyc));
    else             check("done_seen", {63'd0, got > 0}, 64'd1);
    @(negedge clk);
    #1;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("busy_after_done", {63'd0, busy}, 64'd0);
    check("done_low", {63'd0, done}, 64'd0);
    check("exp_wr_left", 64'(exp_q.size()), 64'd0);
    check("exp_rd_left", 64'(exp_rd_q.size()), 64'd0);
    if (len == 11'd0) check("no_traffic", 64'(act_cnt), 64'd0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", 64'(bad), 64'd0);
`ifdef COPY_MASTER_CHECKSUM_EN
    check("csum_final", {32'd0, checksum}, {32'd0, exp_sum});
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int tries;
    reset_n  = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_words_left", {53'd0, words_left}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    check("rst_read", {63'd0, bus.avm_read}, 64'd0);
    check("rst_write", {63'd0, bus.avm_write}, 64'd0);
    check("rst_address", {54'd0, bus.avm_address}, 64'd0);
    check("rst_writedata", {32'd0, bus.avm_writedata}, 64'd0);
    check("rst_byteenable", {60'd0, bus.avm_byteenable}, 64'hF);
`ifdef COPY_MASTER_CHECKSUM_EN
    check("rst_checksum", {32'd0, checksum}, 64'd0);
`endif
    reset_n = 1'b1;

    // Directed zero-wait copy of four known words.
    for (int i = 0; i < 4; i++) mem[10'h010 + i] = 32'h11111111 * (i + 1);
    run_copy(10'h010, 10'h100, 11'd4, 17);
    for (int i = 0; i < 4; i++)
      check("directed_word", {32'd0, mem[10'h100 + i]}, {32'd0, 32'h11111111 * (i + 1)});

    run_copy(10'h055, 10'h0AA, 11'd0, 1);

    // Stalls and variable read latency.
    wait_pct = 50;
    lat_lo   = 1;
    lat_hi   = 5;
    spur_en  = 1;
    run_copy(10'($urandom_range(0, 400)), 10'($urandom_range(500, 900)), 11'd16, 0);

    // Source wrap at the top of the address space, zero-wait timing.
    wait_pct = 0;
    lat_hi   = 1;
    spur_en  = 0;
    run_copy(10'h3FE, 10'h200, 11'd4, 17);

    wait_pct = 30;
    lat_hi   = 3;
    spur_en  = 1;
    for (int k = 0; k < 4; k++)
      run_copy(10'($urandom), 10'($urandom), 11'($urandom_range(1, 24)), 0);

`ifdef COPY_MASTER_CHECKSUM_EN
    wait_pct = 0;
    lat_hi   = 1;
    spur_en  = 0;
    mem[10'h020] = 32'hFFFFFFFF;
    mem[10'h021] = 32'h00000002;
    run_copy(10'h020, 10'h040, 11'd2, 9);
    check("csum_directed", {32'd0, checksum}, 64'd1);
    run_copy(10'h030, 10'h060, 11'd3, 13);
`endif

    // Reset during the third word's write request.
    wait_pct = 0;
    lat_hi   = 1;
    spur_en  = 0;
    ref_mem  = mem;
    model_prepare(10'h080, 10'h180, 11'd8);
    wr_cnt = 0;
    @(posedge clk);
    #1;
    start    = 1'b1;
    src_addr = 10'h080;
    dst_addr = 10'h180;
    length   = 11'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    tries = 0;
    while (!(bus.avm_write && wr_cnt == 2) && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    check("third_write_seen", {63'd0, bus.avm_write && wr_cnt == 2}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_write", {63'd0, bus.avm_write}, 64'd0);
    check("rst_mid_read", {63'd0, bus.avm_read}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_rd_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_writes", 64'(wr_cnt), 64'd2);
    run_copy(10'h080, 10'h180, 11'd8, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
